// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// FSM state encoding, error codes and default memory sizing.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_COUNT,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [1:0] NONE      = 2'b00;
   localparam logic [1:0] BAD_COUNT = 2'b01;
   localparam logic [1:0] BAD_CSUM  = 2'b10;

   // 256-byte instruction memory holds 64 words
   localparam int DEF_MAX_WORDS = 64;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR of the streamed instruction bytes.
// Clear has priority over enable.
module loader_checksum (
   input  logic       clk,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge clk) begin
      if (clear)
         sum <= 8'h00;
      else if (en)
         sum <= sum ^ din;
   end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: count, 4N bytes, XOR checksum.
// Holds the CPU in reset until a load completes cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MAX_WORDS = DEF_MAX_WORDS,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              cnt_ok;
   logic              is_last;
   logic              csum_ok;
   logic              finished;
   logic [7:0]        n;
   logic [ADDR_W-1:0] idx;
   logic [7:0]        sum;
   logic [ADDR_W+1:0] last_w;

   assign accept   = in_valid && in_ready;
   assign cnt_ok   = (in_data != 8'd0) && (int'(in_data) <= MAX_WORDS);
   // widened so that 4*N-1 is exact even at N = MAX_WORDS
   assign last_w   = (ADDR_W+2)'({n, 2'b00}) - (ADDR_W+2)'(1);
   assign is_last  = ((ADDR_W+2)'(idx) == last_w);
   assign csum_ok  = (in_data == sum);
   assign finished = (state == S_DONE) || (state == S_ERR);

   loader_checksum u_csum (
      .clk   (clk),
      .clear (rst || (state == S_COUNT && accept)),
      .en    (state == S_DATA && accept),
      .din   (in_data),
      .sum   (sum)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_COUNT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_COUNT:
            if (accept)
               state_nxt = cnt_ok ? S_DATA : S_ERR;
         S_DATA:
            if (accept && is_last)
               state_nxt = S_CHECK;
         S_CHECK:
            if (accept)
               state_nxt = csum_ok ? S_DONE : S_ERR;
         S_DONE, S_ERR:
            if (reload)
               state_nxt = S_COUNT;
         default:
            state_nxt = S_COUNT;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_hold = 1'b1;
      unique case (state)
         S_COUNT, S_DATA, S_CHECK:
            in_ready = 1'b1;
         S_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         S_ERR:
            err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n         <= 8'd0;
         idx       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'd0;
         err_code  <= NONE;
      end else begin
         mem_we <= 1'b0;
         if (state == S_COUNT && accept) begin
            if (cnt_ok) begin
               n   <= in_data;
               idx <= '0;
            end else begin
               err_code <= BAD_COUNT;
            end
         end
         if (state == S_DATA && accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= in_data;
            idx       <= idx + 1'b1;
         end
         if (state == S_CHECK && accept && !csum_ok)
            err_code <= BAD_CSUM;
         if (finished && reload)
            err_code <= NONE;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader with a write scoreboard.
// Expected writes are queued when bytes are driven, popped on mem_we.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       reload = 1'b0;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(64), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   // advance one cycle and score any write that appears
   task automatic tick();
      logic [15:0] e;
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) begin
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL write got=%h/%h exp=%h/%h",
                        mem_addr, mem_wdata, e[15:8], e[7:0]);
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] a, input logic [7:0] b);
      exp_q.push_back({a, b});
      send(b);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
   endtask

   task automatic drain(input string name);
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing_writes got=%0d exp=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({cpu_hold, done, err, err_code, in_ready} !== 6'b100001) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=100001",
                  {cpu_hold, done, err, err_code, in_ready});
      end
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== 17'd0) begin
         errors++;
         $display("FAIL reset_mem got=%b/%h/%h exp=0/00/00",
                  mem_we, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_normal();
      send(8'h01);
      send_data(8'd0, 8'h20);
      send_data(8'd1, 8'h08);
      send_data(8'd2, 8'h00);
      send_data(8'd3, 8'h05);
      send(8'h2D);
      checks++;
      if ({done, cpu_hold, err, in_ready} !== 4'b1000) begin
         errors++;
         $display("FAIL normal_done got=%b exp=1000", {done, cpu_hold, err, in_ready});
      end
      // bytes offered while not ready must be ignored
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) tick();
      in_valid = 1'b0;
      drain("normal");
      checks++;
      if ({done, cpu_hold} !== 2'b10) begin
         errors++;
         $display("FAIL done_hold_steady got=%b exp=10", {done, cpu_hold});
      end
      pulse_reload();
      checks++;
      if ({done, cpu_hold, err, err_code, in_ready} !== 6'b010001) begin
         errors++;
         $display("FAIL reload_from_done got=%b exp=010001",
                  {done, cpu_hold, err, err_code, in_ready});
      end
   endtask

   task automatic test_bad_count();
      logic [7:0] cnt[2];
      cnt[0] = 8'h00;
      cnt[1] = 8'h41;
      foreach (cnt[i]) begin
         send(cnt[i]);
         tick();
         checks++;
         if ({err, err_code, cpu_hold, done, in_ready} !== 6'b101100) begin
            errors++;
            $display("FAIL bad_count_%0d got=%b exp=101100", i,
                     {err, err_code, cpu_hold, done, in_ready});
         end
         pulse_reload();
         checks++;
         if ({err, err_code, in_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reload_from_err_%0d got=%b exp=0001", i,
                     {err, err_code, in_ready});
         end
      end
      drain("bad_count");
   endtask

   task automatic test_csum_error();
      send(8'h01);
      send_data(8'd0, 8'h11);
      pulse_reload();
      send_data(8'd1, 8'h22);
      send_data(8'd2, 8'h33);
      send_data(8'd3, 8'h44);
      send(8'h00);
      checks++;
      if ({err, err_code, cpu_hold, done, in_ready} !== 6'b110100) begin
         errors++;
         $display("FAIL csum_err got=%b exp=110100",
                  {err, err_code, cpu_hold, done, in_ready});
      end
      drain("csum");
      pulse_reload();
   endtask

   task automatic test_back_to_back();
      logic [7:0] b;
      logic [7:0] x;
      int start;
      x = 8'h00;
      start = wr_count;
      send(8'd64);
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) tick();
         b = 8'($urandom_range(0, 255));
         x = x ^ b;
         send_data(8'(i), b);
      end
      repeat (2) tick();
      send(x);
      checks++;
      if ({done, err, cpu_hold} !== 3'b100) begin
         errors++;
         $display("FAIL full_load_done got=%b exp=100", {done, err, cpu_hold});
      end
      drain("full");
      checks++;
      if (wr_count - start != 256) begin
         errors++;
         $display("FAIL full_load_writes got=%0d exp=256", wr_count - start);
      end
   endtask

   task automatic test_reset_mid();
      pulse_reload();
      send(8'h02);
      for (int i = 0; i < 6; i++)
         send_data(8'(i), 8'(8'hA0 + i));
      // byte offered in the reset cycle must never be written
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if ({cpu_hold, in_ready, done, err, mem_we} !== 5'b11000) begin
         errors++;
         $display("FAIL mid_reset got=%b exp=11000",
                  {cpu_hold, in_ready, done, err, mem_we});
      end
      tick();
      pulse_reload();
      checks++;
      if ({in_ready, err_code} !== 3'b100) begin
         errors++;
         $display("FAIL reload_in_count got=%b exp=100", {in_ready, err_code});
      end
      send(8'h02);
      for (int i = 0; i < 8; i++)
         send_data(8'(i), 8'(8'h10 * i + 1));
      // XOR of 01,11,21,...,71 is 00
      send(8'h00);
      checks++;
      if ({done, cpu_hold} !== 2'b10) begin
         errors++;
         $display("FAIL reload_load_done got=%b exp=10", {done, cpu_hold});
      end
      drain("mid");
      pulse_reload();
      checks++;
      if ({done, cpu_hold, in_ready} !== 3'b011) begin
         errors++;
         $display("FAIL done_cleared got=%b exp=011", {done, cpu_hold, in_ready});
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_bad_count();
      test_csum_error();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, maximum number of 32-bit instruction words loadable; the 256-byte instruction memory gives 256/4.
REQ-002 Parameter ADDR_W, default 8, byte-address width of the instruction memory write port.
REQ-003 Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.
REQ-004 Port `clk`, input, 1, rising-edge clock.
REQ-005 Port `rst`, input, 1, synchronous active-high reset.
REQ-006 Port `in_valid`, input, 1, byte-stream producer has a byte on `in_data`.
REQ-007 Port `in_data`, input, 8, stream byte.
REQ-008 Port `in_ready`, output, 1, loader accepts a byte this cycle.
REQ-009 Port `reload`, input, 1, single-cycle request to start a new load from DONE or ERR.
REQ-010 Port `mem_we`, output, 1, instruction-memory byte write strobe.
REQ-011 Port `mem_addr`, output, ADDR_W, write byte address.
REQ-012 Port `mem_wdata`, output, 8, write byte.
REQ-013 Port `cpu_hold`, output, 1, holds the CPU in reset while high.
REQ-014 Port `done`, output, 1, load completed with a valid checksum.
REQ-015 Port `err`, output, 1, load aborted.
REQ-016 Port `err_code`, output, 2: 00 none, 01 bad count, 10 checksum mismatch.

Function
REQ-017 Transfer rule: a byte transfers on a rising edge where `in_valid && in_ready`.
REQ-018 Stream format:
- Byte 0: word count N.
- Then 4N data bytes, in instruction-memory byte order (byte 4k = word k bits[31:24]).
- Then 1 checksum byte = XOR of all 4N data bytes.
REQ-019 FSM states: COUNT, DATA, CHECK, DONE, ERR.
- `in_ready` is 1 in COUNT, DATA and CHECK; 0 in DONE and ERR.
REQ-020 COUNT, byte accepted:
- N in 1..MAX_WORDS: latch N, clear byte index and checksum, go to DATA.
- Otherwise: go to ERR with `err_code`=01.
REQ-021 DATA, each accepted byte:
- Next cycle: `mem_we`=1, `mem_addr`=byte index, `mem_wdata`=byte (one-cycle registered latency).
- Byte index increments; checksum ^= byte.
- After byte 4N-1 is accepted, go to CHECK.
REQ-022 `mem_we` is 0 in every cycle not following a DATA acceptance; `mem_addr`/`mem_wdata` hold their last value.
REQ-023 CHECK, byte accepted:
- Equals checksum: go to DONE.
- Otherwise: go to ERR with `err_code`=10.
REQ-024 Output encoding by state:
- DONE: `done`=1, `cpu_hold`=0, `err`=0.
- ERR: `err`=1, `cpu_hold`=1, `done`=0.
- All other states: `done`=0, `err`=0, `cpu_hold`=1.
REQ-025 Reload:
- `reload`=1 in DONE or ERR: next state COUNT; `cpu_hold`=1, `done`=0, `err`=0, `err_code`=00 from the next cycle.
- `reload` in any other state is ignored.
REQ-026 Bytes with `in_valid`=1 while `in_ready`=0 are not consumed and cause no state change.
REQ-027 Byte index is ADDR_W wide and never wraps, because 4*MAX_WORDS <= 2^ADDR_W; the last address written is 4N-1.
REQ-028 Idle gaps (`in_valid`=0) of any length in any state leave all state unchanged.

Reset
REQ-029 Reset values on `rst`=1 at a rising edge:
- State COUNT; byte index 0; checksum 0; N 0.
- `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `cpu_hold`=1, `done`=0, `err`=0, `err_code`=00.
REQ-030 Reset mid-load abandons the transfer:
- Bytes already written remain in memory.
- No `mem_we` pulse occurs in the cycle after reset, even if a byte was accepted in the reset cycle.
REQ-031 `rst` has priority over `reload` and over stream transfers.

Structure
REQ-032 Shared package `imem_loader_pkg` holds the FSM state enumeration, the `err_code` constants (NONE, BAD_COUNT, BAD_CSUM) and the default MAX_WORDS.
REQ-033 Hierarchy: single module; the XOR checksum accumulator is the only natural sub-module, named `loader_checksum` (clear, enable, byte in, 8-bit sum out).

Verification
REQ-034 Normal load: stream 01, 20 08 00 05, csum 2D.
- `mem_we` pulses at addr 0..3 with data 20,08,00,05.
- `done`=1 and `cpu_hold`=0 the cycle after the csum byte is accepted.
REQ-035 Bad count: stream 00, then 41.
- ERR with `err_code`=01; no `mem_we`.
- Repeated with count byte 41 (65 > MAX_WORDS): same result.
REQ-036 Checksum error: stream 01, 11 22 33 44, csum 00.
- Four writes occur.
- `err`=1, `err_code`=10, `cpu_hold` stays 1, `in_ready`=0 afterwards.
REQ-037 Backpressure and gaps: random `in_valid` gaps during a 64-word load.
- 256 writes to addresses 0..255, in order, no wrap.
- `done` set.
REQ-038 Reset mid-DATA after 6 bytes, then `reload` then a full 2-word load.
- Reset returns to COUNT with `cpu_hold`=1.
- Subsequent load writes from address 0.
- A `reload` pulse in DONE restarts with `done` cleared next cycle.
